// File: rtl/spi_ram_req_arbiter.sv
// rtl/spi_ram_req_arbiter.sv - two-requester SPI frame sequencer with address/data bus locking
module spi_ram_req_arbiter #(
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_cmd,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_cmd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO,
    output logic              busy
);
    localparam int FRAME_W = DATA_W + 3;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {IDLE, SHIFT, TURN, RECV, GAP} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [FRAME_W-1:0]  frame_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic                cmd_rd;
    logic                cur_id;
    logic                lock, lock_owner, lock_rd;
    logic                rr_ptr;
    logic                grant, grant_vld, accept;
    logic [1:0]          sel_cmd;
    logic [DATA_W-1:0]   sel_data;

    // While locked only the owner may win, so the pending address stays intact.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        if (lock) begin
            grant     = lock_owner;
            grant_vld = lock_owner ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            grant     = rr_ptr;
            grant_vld = 1'b1;
        end else if (req0_valid) begin
            grant     = 1'b0;
            grant_vld = 1'b1;
        end else if (req1_valid) begin
            grant     = 1'b1;
            grant_vld = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_vld && !rst;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign sel_cmd    = grant ? req1_cmd : req0_cmd;
    assign sel_data   = grant ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = SHIFT;
            SHIFT: if (cnt == CNT_W'(FRAME_W - 1)) state_nx = cmd_rd ? TURN : GAP;
            TURN:  if (cnt == CNT_W'(TURN_CYC - 1)) state_nx = RECV;
            RECV:  if (cnt == CNT_W'(DATA_W - 1)) state_nx = GAP;
            GAP:   if (cnt == CNT_W'(GAP_CYC - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        SS_n = !((state == SHIFT) || (state == TURN) || (state == RECV));
        MOSI = (state == SHIFT) ? frame_sr[FRAME_W-1] : 1'b0;
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            frame_sr   <= '0;
            rx_sr      <= '0;
            cmd_rd     <= 1'b0;
            cur_id     <= 1'b0;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
            lock_rd    <= 1'b0;
            rr_ptr     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state_nx != state || state == IDLE) cnt <= '0;
            else                                    cnt <= cnt + 1'b1;

            if (accept) begin
                frame_sr <= {sel_cmd[1], sel_cmd, sel_data};
                cmd_rd   <= (sel_cmd == 2'b11);
                cur_id   <= grant;
                if (!lock) rr_ptr <= !grant;
                case (sel_cmd)
                    2'b00: begin lock <= 1'b1; lock_owner <= grant; lock_rd <= 1'b0; end
                    2'b10: begin lock <= 1'b1; lock_owner <= grant; lock_rd <= 1'b1; end
                    2'b01: if (lock && lock_owner == grant && !lock_rd) lock <= 1'b0;
                    default: if (lock && lock_owner == grant && lock_rd) lock <= 1'b0;
                endcase
            end else if (state == SHIFT) begin
                frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
            end

            if (state == RECV) begin
                rx_sr <= {rx_sr[DATA_W-2:0], MISO};
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cur_id;
                    rsp_data  <= {rx_sr[DATA_W-2:0], MISO};
                end
            end
        end
    end
endmodule

// File: doc/spi_ram_req_arbiter.md
Name: spi_ram_req_arbiter

Overview:
- Master-side sequencer that shares the SPI slave + dual-port RAM between two requesters.
- Arbitrates single-command requests and serialises each one into an SPI frame on SS_n/MOSI.
- For read-data commands, captures the 8-bit MISO reply and returns it to the owning requester.
- Locks the bus to one requester across an address/data pair so a stored RAM address is never clobbered by the other requester.

Parameters:
- DATA_W, 8, payload width of the data byte and of the MISO reply.
- TURN_CYC, 1, cycles SS_n stays low between the last MOSI bit and the first MISO sample (range 1..4).
- GAP_CYC, 1, minimum cycles SS_n is held high between frames (range 1..4).

Ports:
- clk  in  1  Single clock; every register updates on its rising edge.
- rst  in  1  Synchronous reset, active-high.
- req0_valid  in  1  Requester 0 has a command.
- req0_ready  out  1  Requester 0's command is accepted this cycle.
- req0_cmd  in  2  Command: 00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data.
- req0_data  in  DATA_W  Address or data byte; ignored for 11.
- req1_valid, req1_ready, req1_cmd, req1_data: same as requester 0.
- rsp_valid  out  1  One-cycle pulse; read data is valid.
- rsp_id  out  1  Requester that issued the rd_data command.
- rsp_data  out  DATA_W  Byte captured from MISO.
- SS_n  out  1  Slave select, active-low.
- MOSI  out  1  Serial data to the slave.
- MISO  in  1  Serial data from the slave.
- busy  out  1  High in every state except IDLE.

Behaviour:
- States: IDLE, SHIFT, TURN, RECV, GAP.
- Reset values, applied on the edge where rst=1:
  - state=IDLE, SS_n=1, MOSI=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - lock=0, rr_ptr=0 (requester 0 has priority).
  - req*_ready is forced to 0 while rst=1.
- Grant (combinational):
  - If lock=1, only the lock owner can be granted.
  - Otherwise, a single valid requester is granted.
  - If both are valid, the requester selected by rr_ptr is granted.
- Handshake:
  - req_i_ready = (state==IDLE) && grant==i && !rst.
  - Accept occurs when valid && ready.
  - The requester must hold cmd/data stable while valid=1 and ready=0.
- On accept, latch the frame = {cmd[1], cmd[1:0], data} (11 bits, MSB first) and set rr_ptr to the other requester.
- SHIFT (11 cycles):
  - Starts on the cycle after accept.
  - SS_n=0; MOSI=frame[10-k] on shift cycle k.
  - Accept-to-first-MOSI latency is 1 cycle.
  - After the last bit: cmd==11 goes to TURN; any other cmd goes to GAP.
- TURN (TURN_CYC cycles): SS_n=0, MOSI=0.
- RECV (DATA_W cycles):
  - SS_n=0, MOSI=0.
  - MISO is shifted in MSB first on each edge.
  - On the edge after the last sample: rsp_valid=1 for exactly 1 cycle, with rsp_data and rsp_id set; go to GAP.
- GAP (GAP_CYC cycles): SS_n=1, MOSI=0, then IDLE. A new accept can occur in the first IDLE cycle.
- Lock rules (updated on accept):
  - cmd 00 sets lock, owner=i, pend=wr.
  - cmd 10 sets lock, owner=i, pend=rd.
  - The owner's cmd 01 with pend=wr clears lock.
  - The owner's cmd 11 with pend=rd clears lock.
  - An owner command that does not match pend re-locks according to the new command; cmd 01/11 with no match keeps lock unchanged.
  - A non-owner is never granted while lock=1.
- rr_ptr is not updated by accepts that occur while lock=1.
- Reset mid-frame: the next edge forces SS_n=1 and IDLE, and clears lock. No rsp_valid is produced for the aborted frame.
- rsp_valid does not wait for a consumer. The requester must sample it in the pulse cycle.

Test Plan:
- Write pair: req0 sends 00/0x3C, then 01/0xA5 → MOSI frames 0_00_00111100 and 0_01_10100101, each with SS_n low 11 cycles; GAP 1 cycle between frames; first MOSI bit 1 cycle after accept.
- Read pair: req1 sends 10/0x07, then 11; MISO drives 0x5A after 1 turnaround cycle → rsp_valid pulses once 1 cycle after the 8th sample, with rsp_id=1 and rsp_data=0x5A; SS_n low for 11+1+8 cycles.
- Lock: req0 sends 10/0x10 while req1_valid is held high → req1_ready stays 0 until req0's 11 is accepted; req1 is granted in the next IDLE.
- Round-robin: both requesters hold wr_data commands continuously (no lock) → grants alternate 0,1,0,1 from reset.
- Reset mid-frame: rst asserted on the 5th SHIFT cycle of a rd_addr → SS_n=1 and busy=0 the next cycle; lock=0, so req1 is granted immediately after rst is released.
- Back-to-back: req0_valid is held with 01 commands → accept spacing is exactly 1+11+GAP_CYC cycles (13 with defaults).
